fcw_ramp_ctrl: RTL
==================

Name: fcw_ramp_ctrl

Overview:
- Upstream control stage for the fractional-N PLL top; produces the signed fractional offset word `dlf_cont` that the PLL adds to its base sigma-delta alpha.
- Accepts a new target word over a valid/ready handshake and slews `dlf_cont` toward it in bounded steps, so the loop is never hit with a large frequency jump.
- Monitors the TDC output code to report settle, lock, loss-of-lock and timeout.
- Runs on the reference clock (165.289256 MHz domain).

Parameters:
- n, 23, MSB index of the fractional word; `dlf_cont` and `tgt_word` are [n:0] signed.
- TDC_W, 7, TDC code width; the code is two's complement.
- SETTLE_CYC, 256, blanking cycles after the ramp ends, before lock monitoring starts.
- LOCK_WIN, 3, in-window threshold: |tdc_code| <= LOCK_WIN.
- LOCK_CNT, 64, consecutive in-window cycles required to declare lock.
- LOSS_CNT, 8, consecutive out-of-window cycles required to declare loss of lock.
- TIMEOUT_CYC, 65535, maximum TRACK duration before `timeout` is asserted.

Ports:
- clk  in  1  reference clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- tgt_word  in  n+1  signed target fractional offset.
- step_size  in  n+1  unsigned ramp step; 0 is treated as 1.
- tgt_valid  in  1  target offered.
- tgt_ready  out  1  target can be accepted.
- tdc_code  in  TDC_W  signed TDC phase-error code.
- dlf_cont  out  n+1  signed fractional control word to the PLL.
- busy  out  1  high in RAMP, SETTLE or TRACK.
- locked  out  1  lock indication.
- loss_evt  out  1  one-cycle pulse on loss of lock.
- timeout  out  1  sticky; cleared on next accept.

Behaviour:
- Reset (asynchronous, takes effect mid-operation as well): state=IDLE, dlf_cont=0, tgt_ready=1, busy=0, locked=0, loss_evt=0, timeout=0, all counters=0.
- States: IDLE, RAMP, SETTLE, TRACK, LOCKED.
- tgt_ready=1 only in IDLE and LOCKED; combinationally derived from the registered state.
- Accept occurs on a clk edge where tgt_valid and tgt_ready are both high:
  - register tgt_word and max(step_size,1);
  - clear timeout and locked on that edge;
  - next state = RAMP.
- An offer is held while tgt_ready=0; it is never dropped and never partially captured.
- RAMP, every cycle:
  - diff = tgt - dlf_cont, computed in n+2 bits signed (no overflow).
  - If |diff| <= step: dlf_cont <= tgt and go to SETTLE.
  - Else: dlf_cont <= dlf_cont + sign(diff)*step.
  - If tgt equals the current dlf_cont at accept, RAMP lasts exactly 1 cycle.
  - dlf_cont never overshoots tgt.
- SETTLE: counts SETTLE_CYC cycles, ignoring tdc_code, then goes to TRACK with the lock counter and timeout counter at 0.
- TRACK:
  - In-window cycle: lock_cnt increments. Out-of-window cycle: lock_cnt clears.
  - When lock_cnt reaches LOCK_CNT: go to LOCKED, locked=1 on that edge.
  - When the timeout counter reaches TIMEOUT_CYC: timeout=1 (sticky); stay in TRACK.
- LOCKED:
  - loss_cnt counts consecutive out-of-window cycles and clears on an in-window cycle.
  - When loss_cnt reaches LOSS_CNT: locked=0, loss_evt=1 for one cycle, go to TRACK.
  - An accept in LOCKED takes priority over a loss event on the same cycle: go to RAMP, and no loss_evt is issued.
- |tdc_code| is computed in TDC_W+1 bits, so the most negative code (-64) does not wrap.
- dlf_cont holds its value in all states except RAMP.

Decomposition:
- Package `pll_ctrl_pkg`:
  - state enum `fcw_state_t`;
  - TDC_W default;
  - function `abs_tdc` (TDC_W+1 result).
- Sub-module `pll_lock_counter`:
  - parameters WIN, CNT;
  - inputs clk, rst, clr, tdc_code;
  - output `hit` when CNT consecutive in-window samples have been seen.
  - Instantiated once for lock (in-window counting) and once for loss (inverted-window counting).

Test Plan:
- Reset then tgt_word=40000, step_size=1024, one-cycle handshake:
  - dlf_cont=1024,2048,…,39936 over 39 cycles, then 40000 on the 40th RAMP cycle;
  - busy=1 from the cycle after accept; tgt_ready=0 during RAMP.
- From 0, tgt_word=-5000, step=2000 -> dlf_cont = -2000, -4000, -5000 (3 cycles); step_size=0 with target 3 -> 1, 2, 3.
- After the ramp, tdc_code=0 constant -> locked rises exactly SETTLE_CYC+LOCK_CNT cycles after RAMP exits; an out-of-window code (5) inserted at the 63rd TRACK cycle restarts the 64-cycle count.
- While LOCKED, tdc_code=10 for 7 cycles, then 0 -> stays locked; tdc_code=10 for 8 cycles -> loss_evt single pulse, locked=0, state TRACK.
- In TRACK with tdc_code=-64 (magnitude 64, no wrap) held -> timeout=1 after 65535 cycles, stays 1; the next accept clears it.
- Assert rst mid-RAMP with dlf_cont=20480 -> dlf_cont=0 and tgt_ready=1 immediately (asynchronous); a tgt_valid held across RAMP is accepted on the first cycle in LOCKED.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state type and TDC helpers for the fractional-N PLL control stage
package pll_ctrl_pkg;

    localparam int TDC_W_DEFAULT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_SETTLE,
        ST_TRACK,
        ST_LOCKED
    } fcw_state_t;

    // One bit wider than the code so the most negative code keeps its true magnitude.
    function automatic logic [TDC_W_DEFAULT:0] abs_tdc(input logic signed [TDC_W_DEFAULT-1:0] code);
        logic signed [TDC_W_DEFAULT:0] ext;
        ext = {code[TDC_W_DEFAULT-1], code};
        if (ext[TDC_W_DEFAULT]) begin
            ext = -ext;
        end
        return ext;
    endfunction

endpackage

// File: rtl/pll_lock_counter.sv
// rtl/pll_lock_counter.sv - consecutive in-window (or out-of-window) TDC sample counter
module pll_lock_counter
    import pll_ctrl_pkg::*;
#(
    parameter int WIN = 3,
    parameter int CNT = 64,
    parameter bit INV = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic signed [TDC_W_DEFAULT-1:0]  tdc_code,
    output logic                             hit
);

    localparam int CW = $clog2(CNT + 1);

    logic [CW-1:0] cnt;
    logic          in_win;
    logic          match;

    assign in_win = (abs_tdc(tdc_code) <= (TDC_W_DEFAULT + 1)'(WIN));
    assign match  = in_win ^ INV;

    // Fires on the sample that completes the run, so the owner can act on that same edge.
    assign hit = match && (cnt == CW'(CNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !match) begin
            cnt <= '0;
        end else if (cnt != CW'(CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fcw_ramp_ctrl.sv
// rtl/fcw_ramp_ctrl.sv - slews the PLL fractional offset toward a target and monitors lock
module fcw_ramp_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int n           = 23,
    parameter int TDC_W       = TDC_W_DEFAULT,
    parameter int SETTLE_CYC  = 256,
    parameter int LOCK_WIN    = 3,
    parameter int LOCK_CNT    = 64,
    parameter int LOSS_CNT    = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [n:0]       tgt_word,
    input  logic        [n:0]       step_size,
    input  logic                    tgt_valid,
    output logic                    tgt_ready,
    input  logic signed [TDC_W-1:0] tdc_code,
    output logic signed [n:0]       dlf_cont,
    output logic                    busy,
    output logic                    locked,
    output logic                    loss_evt,
    output logic                    timeout
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    fcw_state_t         state, state_nxt;
    logic signed [n:0]  tgt_q, tgt_nxt;
    logic        [n:0]  step_q, step_nxt;
    logic signed [n:0]  dlf_nxt;
    logic [SW-1:0]      settle_cnt, settle_nxt;
    logic [TW-1:0]      tmo_cnt, tmo_nxt;
    logic               locked_nxt, loss_nxt, timeout_nxt;
    logic               accept, lock_hit, loss_hit;
    logic signed [n+1:0] diff;
    logic        [n+1:0] abs_diff, step_ext, ramp_sum;

    assign tgt_ready = (state == ST_IDLE) || (state == ST_LOCKED);
    assign busy      = (state == ST_RAMP) || (state == ST_SETTLE) || (state == ST_TRACK);
    assign accept    = tgt_valid && tgt_ready;

    pll_lock_counter #(.WIN(LOCK_WIN), .CNT(LOCK_CNT), .INV(1'b0)) u_lock (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_TRACK),
        .tdc_code (tdc_code),
        .hit      (lock_hit)
    );

    pll_lock_counter #(.WIN(LOCK_WIN), .CNT(LOSS_CNT), .INV(1'b1)) u_loss (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_LOCKED),
        .tdc_code (tdc_code),
        .hit      (loss_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dlf_nxt     = dlf_cont;
        tgt_nxt     = tgt_q;
        step_nxt    = step_q;
        settle_nxt  = '0;
        tmo_nxt     = '0;
        locked_nxt  = locked;
        loss_nxt    = 1'b0;
        timeout_nxt = timeout;

        // One extra bit keeps the difference exact across the full signed range.
        diff     = {tgt_q[n], tgt_q} - {dlf_cont[n], dlf_cont};
        abs_diff = diff[n+1] ? -diff : diff;
        step_ext = {1'b0, step_q};
        ramp_sum = diff[n+1] ? ({dlf_cont[n], dlf_cont} - step_ext)
                             : ({dlf_cont[n], dlf_cont} + step_ext);

        case (state)
            ST_RAMP: begin
                if (abs_diff <= step_ext) begin
                    dlf_nxt   = tgt_q;
                    state_nxt = ST_SETTLE;
                end else begin
                    dlf_nxt = ramp_sum[n:0];
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_TRACK;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            ST_TRACK: begin
                tmo_nxt = tmo_cnt;
                if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_nxt = 1'b1;
                end
                if (lock_hit) begin
                    state_nxt  = ST_LOCKED;
                    locked_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (loss_hit) begin
                    state_nxt  = ST_TRACK;
                    locked_nxt = 1'b0;
                    loss_nxt   = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // A new target overrides whatever the current state decided, including a loss event.
        if (accept) begin
            tgt_nxt     = tgt_word;
            step_nxt    = (step_size == '0) ? (n+1)'(1) : step_size;
            timeout_nxt = 1'b0;
            locked_nxt  = 1'b0;
            loss_nxt    = 1'b0;
            state_nxt   = ST_RAMP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlf_cont   <= '0;
            tgt_q      <= '0;
            step_q     <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            locked     <= 1'b0;
            loss_evt   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            dlf_cont   <= dlf_nxt;
            tgt_q      <= tgt_nxt;
            step_q     <= step_nxt;
            settle_cnt <= settle_nxt;
            tmo_cnt    <= tmo_nxt;
            locked     <= locked_nxt;
            loss_evt   <= loss_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule
